mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  clock; rst  in  1  reset, synchronous, active-high; rdy  in  1  global enable, all state holds when low.
REQ-002 SHALL have: flush  in  1  discard any in-flight instruction fetch (mispredict).
REQ-003 SHALL have: if_valid in 1; if_addr in 32, 16-byte line-aligned; if_ready out 1, one-cycle pulse; if_line out 128, fetched line, byte 0 in bits [7:0].
REQ-004 SHALL have: ls_valid in 1; ls_wr in 1, 1 = store; ls_addr in 32; ls_type in 3; ls_data in 32; ls_ready out 1, one-cycle pulse; ls_result out 32.
REQ-005 SHALL have toward the memory controller: mem_valid out 1; mem_wr out 1; mem_addr out 32; mem_type out 3; mem_data out 32; mem_ready in 1, one-cycle completion pulse; mem_result in 32.

Function
REQ-006 SHALL implement states IDLE, FETCH, LOAD_STORE.
REQ-007 In IDLE with rdy high, SHALL grant at most one requester per cycle, enter FETCH or LOAD_STORE next cycle, and register all mem_* outputs at that edge.
REQ-008 With both if_valid and ls_valid high in IDLE, SHALL grant the requester not granted last (1-bit round-robin pointer, reset = LS last, so IF wins first).
REQ-009 Requesters SHALL hold valid and payload stable until their ready pulse; the arbiter SHALL latch the payload at grant.
REQ-010 mem_valid SHALL be high in every non-IDLE cycle until and including the cycle mem_ready is sampled high; it SHALL be low in IDLE.
REQ-011 FETCH SHALL issue four word reads (type 3'b010, mem_wr 0) at if_addr+0, +4, +8, +12 using a 2-bit beat counter; on each mem_ready, SHALL store mem_result into line word [beat] and advance mem_addr by 4.
REQ-012 A fetch SHALL be non-preemptible; LS SHALL wait until all four beats finish.
REQ-013 After beat 3 completes, SHALL pulse if_ready for one cycle with if_line valid, return to IDLE, and set the pointer to IF.
REQ-014 LOAD_STORE SHALL issue one access with ls_wr/ls_addr/ls_type/ls_data; on mem_ready SHALL pulse ls_ready next cycle with ls_result = mem_result for loads (0 for stores), return to IDLE, and set the pointer to LS.
REQ-015 Between mem_ready and the next issue SHALL leave at least one cycle with mem_valid low.
REQ-016 flush during FETCH SHALL set a discard flag; the current beat SHALL complete (the controller cannot abort); remaining beats SHALL NOT be issued; if_ready SHALL NOT pulse; state SHALL return to IDLE once the outstanding mem_ready arrives.
REQ-017 flush in IDLE SHALL block a same-cycle IF grant; flush SHALL NOT affect LOAD_STORE.
REQ-018 if_ready and ls_ready SHALL never be high in the same cycle.
REQ-019 mem_ready seen in IDLE SHALL be ignored.
REQ-020 rdy low SHALL freeze state, counters and outputs; a mem_ready pulse is only sampled when rdy is high.

Reset
REQ-021 On rst, SHALL go to IDLE, clear the beat counter and discard flag, set the pointer to LS, and drive every output (mem_*, if_ready, if_line, ls_ready, ls_result) to 0.
REQ-022 rst mid-transaction SHALL abandon it with no ready pulse; the memory controller is reset by the same rst.

Structure
REQ-023 Access-type codes (BYTE 000, HALF 001, WORD 010, BYTE_S 100, HALF_S 101) and the state encoding SHALL live in the shared constants file.
REQ-024 SHALL be a single module with no sub-modules.

Verification
REQ-025 IF-only read of addr 0x1000 with the memory model returning word k = 0x11111111*(k+1): four reads at 0x1000/4/8/C, then if_ready with if_line = 0x44444444_33333333_22222222_11111111.
REQ-026 IF and LS valid in the same IDLE cycle after reset: IF granted first, then LS store (addr 0x200, type 010, data 0xDEADBEEF) issued only after the IF line completes; a second simultaneous request grants IF again.
REQ-027 LS signed byte load (type 100) at an address holding 0x80: ls_ready pulses once with ls_result 0xFFFFFF80, and mem_valid is low for at least one cycle afterwards.
REQ-028 flush asserted during beat 1: beat 1 completes, beats 2-3 are not issued, no if_ready, IDLE after the beat-1 mem_ready; a pending LS request is then granted.
REQ-029 rdy held low for 3 cycles mid-FETCH with mem_ready pulsed during the stall: no state or address change, and the held pulse is consumed only when rdy returns.
REQ-030 rst asserted mid-LS store: all outputs 0 next cycle, no ls_ready, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction-fetch / load-store memory arbiter:
// arbiter state encoding and memory access-type codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    LOAD_STORE = 2'd2
  } state_t;

  localparam logic [2:0] MT_BYTE   = 3'b000;
  localparam logic [2:0] MT_HALF   = 3'b001;
  localparam logic [2:0] MT_WORD   = 3'b010;
  localparam logic [2:0] MT_BYTE_S = 3'b100;
  localparam logic [2:0] MT_HALF_S = 3'b101;

  localparam logic [31:0] BEAT_STRIDE = 32'd4;
  localparam logic [1:0]  LAST_BEAT   = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between 16-byte instruction line fetches and
// single load/store accesses, with 1-bit round-robin and fetch flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         if_valid,
  input  logic [31:0]  if_addr,
  output logic         if_ready,
  output logic [127:0] if_line,
  input  logic         ls_valid,
  input  logic         ls_wr,
  input  logic [31:0]  ls_addr,
  input  logic [2:0]   ls_type,
  input  logic [31:0]  ls_data,
  output logic         ls_ready,
  output logic [31:0]  ls_result,
  output logic         mem_valid,
  output logic         mem_wr,
  output logic [31:0]  mem_addr,
  output logic [2:0]   mem_type,
  output logic [31:0]  mem_data,
  input  logic         mem_ready,
  input  logic [31:0]  mem_result
);

  state_t     state, state_d;
  logic       last_if;   // 1: IF was granted last, 0: LS was granted last
  logic       discard;
  logic       pend;      // completion that arrived while stalled
  logic [1:0] beat;
  logic       grant_if, grant_ls, ack, drop;

  assign ack  = mem_ready | pend;
  assign drop = discard | flush;

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_d;
  end

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    state_d  = state;
    unique case (state)
      IDLE: begin
        grant_if = if_valid && !flush && !(ls_valid && last_if);
        grant_ls = ls_valid && !grant_if;
        if (grant_if)      state_d = FETCH;
        else if (grant_ls) state_d = LOAD_STORE;
      end
      FETCH:      if (ack && (drop || beat == LAST_BEAT)) state_d = IDLE;
      LOAD_STORE: if (ack) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_if   <= 1'b0;
      discard   <= 1'b0;
      pend      <= 1'b0;
      beat      <= 2'd0;
      if_ready  <= 1'b0;
      if_line   <= '0;
      ls_ready  <= 1'b0;
      ls_result <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_type  <= '0;
      mem_data  <= '0;
    end else if (rdy) begin
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      pend     <= 1'b0;
      unique case (state)
        IDLE: begin
          discard <= 1'b0;
          beat    <= 2'd0;
          if (grant_if) begin
            mem_valid <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr;
            mem_type  <= MT_WORD;
            mem_data  <= '0;
          end else if (grant_ls) begin
            mem_valid <= 1'b1;
            mem_wr    <= ls_wr;
            mem_addr  <= ls_addr;
            mem_type  <= ls_type;
            mem_data  <= ls_data;
          end
        end
        FETCH: begin
          if (flush) discard <= 1'b1;
          // A discarded fetch still waits for the beat already on the bus.
          if (ack) begin
            if (drop) begin
              mem_valid <= 1'b0;
            end else begin
              if_line[{beat, 5'd0} +: 32] <= mem_result;
              if (beat == LAST_BEAT) begin
                mem_valid <= 1'b0;
                if_ready  <= 1'b1;
                last_if   <= 1'b1;
              end else begin
                beat     <= beat + 2'd1;
                mem_addr <= mem_addr + BEAT_STRIDE;
              end
            end
          end
        end
        LOAD_STORE: begin
          if (ack) begin
            mem_valid <= 1'b0;
            ls_ready  <= 1'b1;
            ls_result <= mem_wr ? '0 : mem_result;
            last_if   <= 1'b0;
          end
        end
        default: ;
      endcase
    end else if (state != IDLE && mem_ready) begin
      pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a two-cycle-latency memory model plus
// hand-driven completions for stall cases.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic if_valid, if_ready;
  logic [31:0] if_addr;
  logic [127:0] if_line;
  logic ls_valid, ls_wr, ls_ready;
  logic [31:0] ls_addr, ls_data, ls_result;
  logic [2:0] ls_type;
  logic mem_valid, mem_wr, mem_ready;
  logic [31:0] mem_addr, mem_data, mem_result;
  logic [2:0] mem_type;

  logic auto_mem = 1'b1;
  logic a_ready = 1'b0;
  logic [31:0] a_result = '0;
  logic m_ready;
  logic [31:0] m_result;
  assign mem_ready  = auto_mem ? a_ready : m_ready;
  assign mem_result = auto_mem ? a_result : m_result;

  int checks = 0, errors = 0;
  int if_cnt = 0, ls_cnt = 0, both_cnt = 0;

  logic [31:0] mem_words [logic [29:0]];
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [2:0]  log_type[$];
  logic [31:0] log_data[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_line(if_line),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_type(ls_type),
    .ls_data(ls_data), .ls_ready(ls_ready), .ls_result(ls_result),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_type(mem_type),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_result(mem_result)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] w, s;
    w = mem_words.exists(a[31:2]) ? mem_words[a[31:2]] : 32'h0;
    s = w >> {a[1:0], 3'b000};
    case (t)
      MT_BYTE:   return {24'h0, s[7:0]};
      MT_BYTE_S: return {{24{s[7]}}, s[7:0]};
      MT_HALF:   return {16'h0, s[15:0]};
      MT_HALF_S: return {{16{s[15]}}, s[15:0]};
      default:   return w;
    endcase
  endfunction

  // Memory controller model: answers each request two cycles after it appears.
  initial begin
    int cnt;
    cnt = 0;
    mem_words[30'h400] = 32'h11111111;
    mem_words[30'h401] = 32'h22222222;
    mem_words[30'h402] = 32'h33333333;
    mem_words[30'h403] = 32'h44444444;
    mem_words[30'h0C0] = 32'h00008000;
    forever begin
      @(posedge clk); #1;
      if (!auto_mem || a_ready) begin
        a_ready = 1'b0;
        cnt = 0;
      end else if (mem_valid && !rst && rdy) begin
        cnt++;
        if (cnt == 2) begin
          a_ready  = 1'b1;
          a_result = mem_wr ? 32'h0 : rd(mem_addr, mem_type);
          log_addr.push_back(mem_addr);
          log_wr.push_back(mem_wr);
          log_type.push_back(mem_type);
          log_data.push_back(mem_data);
          if (mem_wr) mem_words[mem_addr[31:2]] = mem_data;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (if_ready) if_cnt <= if_cnt + 1;
    if (ls_ready) ls_cnt <= ls_cnt + 1;
    if (if_ready && ls_ready) both_cnt <= both_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Drop each requester's valid once its ready pulse is seen.
  task automatic serve(input string tag);
    int n;
    n = 0;
    while ((if_valid || ls_valid) && n < 60) begin
      @(negedge clk);
      if (if_ready) if_valid = 1'b0;
      if (ls_ready) ls_valid = 1'b0;
      n++;
    end
    chk({tag, "_done"}, {if_valid, ls_valid}, 2'b00);
    @(negedge clk);
  endtask

  task automatic mpulse(input logic [31:0] d);
    m_ready = 1'b1; m_result = d;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base, c0, c1, n;
    rst = 1; rdy = 1; flush = 0;
    if_valid = 0; if_addr = 0;
    ls_valid = 0; ls_wr = 0; ls_addr = 0; ls_type = 0; ls_data = 0;
    m_ready = 0; m_result = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_bus", {mem_wr, mem_addr, mem_type, mem_data}, 0);
    chk("rst_readies", {if_ready, ls_ready}, 0);
    chk("rst_results", {if_line, ls_result}, 0);
    rst = 0;

    // IF-only line fetch
    base = log_addr.size(); c0 = if_cnt;
    if_addr = 32'h1000; if_valid = 1;
    serve("t1");
    chk("t1_beats", log_addr.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_addr%0d", k), log_addr[base+k], 32'h1000 + 4*k);
      chk($sformatf("t1_rd%0d", k), {log_wr[base+k], log_type[base+k]}, {1'b0, 3'b010});
    end
    chk("t1_line", if_line, 128'h44444444_33333333_22222222_11111111);
    chk("t1_if_ready_once", if_cnt - c0, 1);

    // Simultaneous IF and LS right after reset: IF first
    rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    base = log_addr.size(); c1 = ls_cnt;
    if_addr = 32'h1000; if_valid = 1;
    ls_valid = 1; ls_wr = 1; ls_addr = 32'h200; ls_type = MT_WORD; ls_data = 32'hDEADBEEF;
    serve("t2a");
    chk("t2a_count", log_addr.size() - base, 5);
    chk("t2a_if_first", log_addr[base], 32'h1000);
    chk("t2a_if_last", log_addr[base+3], 32'h100C);
    chk("t2a_store", {log_wr[base+4], log_type[base+4], log_addr[base+4], log_data[base+4]},
        {1'b1, 3'b010, 32'h200, 32'hDEADBEEF});
    chk("t2a_store_result", ls_result, 0);
    chk("t2a_ls_once", ls_cnt - c1, 1);
    base = log_addr.size();
    if_valid = 1;
    ls_valid = 1; ls_wr = 0; ls_addr = 32'h1004; ls_type = MT_WORD;
    serve("t2b");
    chk("t2b_if_first", log_addr[base], 32'h1000);
    chk("t2b_ls_after", {log_wr[base+4], log_addr[base+4]}, {1'b0, 32'h1004});
    chk("t2b_load_result", ls_result, 32'h22222222);

    // Signed byte load
    c1 = ls_cnt;
    ls_valid = 1; ls_wr = 0; ls_addr = 32'h301; ls_type = MT_BYTE_S;
    n = 0;
    while (!ls_ready && n < 20) begin @(negedge clk); n++; end
    chk("t3_seen", ls_ready, 1);
    chk("t3_result", ls_result, 32'hFFFFFF80);
    chk("t3_gap", mem_valid, 0);
    ls_valid = 0;
    repeat (3) @(negedge clk);
    chk("t3_once", ls_cnt - c1, 1);
    chk("t3_idle", mem_valid, 0);

    // Flush in IDLE blocks the IF grant
    c0 = if_cnt;
    if_addr = 32'h1000; if_valid = 1; flush = 1;
    @(negedge clk);
    chk("idle_flush_block", mem_valid, 0);
    flush = 0;
    serve("t4a");
    chk("t4a_after_flush", if_cnt - c0, 1);

    // Flush during beat 1 with an LS request waiting
    base = log_addr.size(); c0 = if_cnt; c1 = ls_cnt;
    if_addr = 32'h1000; if_valid = 1;
    @(negedge clk);
    ls_valid = 1; ls_wr = 0; ls_addr = 32'h300; ls_type = MT_WORD;
    n = 0;
    while (!(mem_valid && mem_addr == 32'h1004) && n < 20) begin @(negedge clk); n++; end
    chk("t4_beat1_seen", mem_addr, 32'h1004);
    flush = 1; if_valid = 0;
    @(negedge clk);
    flush = 0;
    serve("t4b");
    chk("t4_issues", log_addr.size() - base, 3);
    chk("t4_beat1", log_addr[base+1], 32'h1004);
    chk("t4_ls_next", log_addr[base+2], 32'h300);
    chk("t4_no_if_ready", if_cnt - c0, 0);
    chk("t4_ls_result", {ls_cnt - c1, ls_result}, {32'd1, 32'h00008000});

    // mem_ready in IDLE is ignored; then a stall during a fetch
    auto_mem = 0;
    m_ready = 1; m_result = 32'h5555;
    @(negedge clk);
    m_ready = 0;
    @(negedge clk);
    chk("idle_ready_ignored", {mem_valid, if_ready, ls_ready}, 0);
    if_addr = 32'h1000; if_valid = 1;
    @(negedge clk);
    chk("t5_issued", {mem_valid, mem_addr}, {1'b1, 32'h1000});
    rdy = 0;
    @(negedge clk);
    m_ready = 1; m_result = 32'hA0A0A0A0;
    @(negedge clk);
    m_ready = 0;
    @(negedge clk);
    chk("t5_stall_addr", {mem_valid, mem_addr}, {1'b1, 32'h1000});
    rdy = 1;
    @(negedge clk);
    chk("t5_consume", mem_addr, 32'h1004);
    @(negedge clk);
    chk("t5_once", mem_addr, 32'h1004);
    mpulse(32'hB0B0B0B0);
    mpulse(32'hC0C0C0C0);
    m_ready = 1; m_result = 32'hD0D0D0D0;
    @(negedge clk);
    m_ready = 0; if_valid = 0;
    chk("t5_if_ready", {if_ready, mem_valid}, 2'b10);
    chk("t5_line", if_line, 128'hD0D0D0D0_C0C0C0C0_B0B0B0B0_A0A0A0A0);
    auto_mem = 1;
    @(negedge clk);

    // Reset in the middle of a store
    base = log_addr.size(); c0 = if_cnt; c1 = ls_cnt;
    ls_valid = 1; ls_wr = 1; ls_addr = 32'h240; ls_type = MT_WORD; ls_data = 32'h12345678;
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    chk("t6_issued", {mem_valid, mem_wr, mem_addr}, {1'b1, 1'b1, 32'h240});
    rst = 1; ls_valid = 0;
    @(negedge clk);
    chk("t6_mem_bus", {mem_valid, mem_wr, mem_addr, mem_type, mem_data}, 0);
    chk("t6_readies", {if_ready, ls_ready}, 0);
    chk("t6_results", {if_line, ls_result}, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("t6_no_ls_ready", ls_cnt - c1, 0);
    chk("t6_no_completion", log_addr.size() - base, 0);
    if_addr = 32'h1000; if_valid = 1;
    serve("t6");
    chk("t6_idle_serves", if_cnt - c0, 1);

    chk("never_both_ready", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
